// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
//
// Receive-side counterpart of the four-digit multiplexed seven-segment driver.
// Watches the scanned DIGS/SEGS bus, waits for each {DIGS,SEGS} pair to settle,
// decodes the segment pattern back to a BCD nibble and collects the four digits
// into a shadow frame. Once every digit has been seen, the frame is committed to
// the outputs together with a one-cycle valid pulse.
//
// Ports:
//   clk     system clock
//   reset   asynchronous, active-low reset
//   DIGS    digit enables, one-hot, bit n = digit n
//   SEGS    [7] = dot, [6:0] = segments a..g (a = bit 6)
//   BCD     reconstructed digits, digit n in BCD[4n+3:4n]
//   DOT     reconstructed dot per digit
//   BI      1 when the last committed frame was fully blank (dots included)
//   valid   one-cycle pulse when a frame is committed
//   err     per-digit invalid-pattern flag of the committed frame
//   stale   no frame committed for TIMEOUT clocks
// -----------------------------------------------------------------------------
module seven_seg_capture #(
    parameter int STABLE_CNT = 16,
    parameter int TIMEOUT    = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  DIGS,
    input  logic [7:0]  SEGS,
    output logic [15:0] BCD,
    output logic [3:0]  DOT,
    output logic        BI,
    output logic        valid,
    output logic [3:0]  err,
    output logic        stale
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX     = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_CAPTURE = CW'(STABLE_CNT - 1);
    localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT);

    logic [11:0]   s_reg;
    logic [3:0]    s_digs;
    logic [7:0]    s_segs;
    logic [CW-1:0] stable_cnt;
    logic          capture;
    logic          commit;
    logic [1:0]    digit_idx;
    logic [3:0]    dec_nibble;
    logic          dec_err;
    logic [3:0]    seen;
    logic [15:0]   shadow_bcd;
    logic [3:0]    shadow_dot;
    logic [3:0]    shadow_err;
    logic [3:0]    shadow_blank;
    logic [TW-1:0] tmo_cnt;

    assign s_digs = s_reg[11:8];
    assign s_segs = s_reg[7:0];

    // Input register and stability counter. The incoming pair is compared with
    // the registered copy, so the counter restarts in the same edge that s_reg
    // takes a new value and always describes how long s_reg has been steady.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_reg      <= '0;
            stable_cnt <= '0;
        end else begin
            s_reg <= {DIGS, SEGS};
            if ({DIGS, SEGS} != s_reg) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    // The counter passes through STABLE_CNT-1 exactly once per stable period
    // because it saturates one step later, giving a single capture per period.
    // Idle (no digit) or overlapping enables are silently ignored.
    assign capture = (stable_cnt == CNT_CAPTURE) && $onehot(s_digs);
    assign commit  = (seen == 4'b1111);

    // One-hot digit enable to slot index.
    always_comb begin
        digit_idx = 2'd0;
        case (s_digs)
            4'b0010: digit_idx = 2'd1;
            4'b0100: digit_idx = 2'd2;
            4'b1000: digit_idx = 2'd3;
            default: digit_idx = 2'd0;
        endcase
    end

    // Segment pattern to BCD. A dark digit decodes to F without an error so a
    // blanked display is distinguishable from a corrupted one.
    always_comb begin
        dec_nibble = 4'hF;
        dec_err    = 1'b0;
        case (s_segs[6:0])
            7'h7E:   dec_nibble = 4'd0;
            7'h30:   dec_nibble = 4'd1;
            7'h6D:   dec_nibble = 4'd2;
            7'h79:   dec_nibble = 4'd3;
            7'h33:   dec_nibble = 4'd4;
            7'h5B:   dec_nibble = 4'd5;
            7'h5F:   dec_nibble = 4'd6;
            7'h70:   dec_nibble = 4'd7;
            7'h7F:   dec_nibble = 4'd8;
            7'h7B:   dec_nibble = 4'd9;
            7'h00:   dec_nibble = 4'hF;
            default: dec_err    = 1'b1;
        endcase
    end

    // Shadow frame and seen mask. A digit captured again before the frame is
    // complete simply overwrites its slot. A capture landing on the commit edge
    // starts the next frame instead of being dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_bcd   <= '0;
            shadow_dot   <= '0;
            shadow_err   <= '0;
            shadow_blank <= '0;
            seen         <= '0;
        end else begin
            if (capture) begin
                shadow_bcd[{digit_idx, 2'b00} +: 4] <= dec_nibble;
                shadow_dot[digit_idx]               <= s_segs[7];
                shadow_err[digit_idx]               <= dec_err;
                shadow_blank[digit_idx]             <= (s_segs == 8'h00);
            end
            if (commit) begin
                seen <= capture ? s_digs : 4'b0000;
            end else if (capture) begin
                seen <= seen | s_digs;
            end
        end
    end

    // Committed frame. Outputs only change on a commit and hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BCD   <= 16'h0000;
            DOT   <= '0;
            err   <= '0;
            BI    <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= commit;
            if (commit) begin
                BCD <= shadow_bcd;
                DOT <= shadow_dot;
                err <= shadow_err;
                BI  <= &shadow_blank;
            end
        end
    end

    // Scan watchdog. Cleared on the commit edge so stale is already low in the
    // cycle that valid is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (commit) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign stale = (tmo_cnt == TMO_MAX);

endmodule

// File: tb/tb_seven_seg_capture.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_capture
//
// Drives the display bus as a series of (DIGS, SEGS, hold-time) segments. A
// pin-level reference model decides which held values become captures, builds
// complete frames and queues them with the cycle they must appear on. A
// separate monitor pops the queue whenever valid pulses and checks that outputs
// hold between commits.
// -----------------------------------------------------------------------------
module tb_seven_seg_capture;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 100;

    localparam logic [6:0] SEG_TABLE [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dot;
        logic [3:0]  err;
        logic        bi;
        int          due;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  DIGS = 4'b0000;
    logic [7:0]  SEGS = 8'h00;
    logic [15:0] BCD;
    logic [3:0]  DOT;
    logic        BI;
    logic        valid;
    logic [3:0]  err;
    logic        stale;

    int     cyc = 0;
    int     n_vectors = 0;
    int     n_miscompares = 0;
    frame_t exp_q[$];

    // Reference model state
    logic [11:0] m_last = '0;
    int          m_run = 0;
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_dot = '0;
    logic [3:0]  m_err = '0;
    logic [3:0]  m_blank = '0;
    logic [3:0]  m_seen = '0;

    seven_seg_capture #(.STABLE_CNT(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .DIGS  (DIGS),
        .SEGS  (SEGS),
        .BCD   (BCD),
        .DOT   (DOT),
        .BI    (BI),
        .valid (valid),
        .err   (err),
        .stale (stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] seg, output logic [3:0] nib,
                                       output logic bad);
        nib = 4'hF;
        bad = (seg != 7'h00);
        for (int i = 0; i < 10; i++) begin
            if (seg == SEG_TABLE[i]) begin
                nib = 4'(i);
                bad = 1'b0;
            end
        end
    endfunction

    // A value held on the pins for STABLE consecutive clocks is captured once;
    // a frame is due two clocks after the sampling edge of its last capture.
    task automatic model_step(input logic [3:0] d, input logic [7:0] s);
        logic [3:0] nib;
        logic       bad;
        int         n;
        frame_t     f;
        if (m_run == 0 || {d, s} != m_last) begin
            m_last = {d, s};
            m_run  = 1;
        end else begin
            m_run++;
        end
        if (m_run == STABLE && $onehot(d)) begin
            n = 0;
            for (int k = 0; k < 4; k++) if (d[k]) n = k;
            ref_decode(s[6:0], nib, bad);
            m_bcd[4*n +: 4] = nib;
            m_dot[n]   = s[7];
            m_err[n]   = bad;
            m_blank[n] = (s == 8'h00);
            m_seen[n]  = 1'b1;
            if (m_seen == 4'hF) begin
                f.bcd = m_bcd;
                f.dot = m_dot;
                f.err = m_err;
                f.bi  = &m_blank;
                f.due = cyc + 3;
                exp_q.push_back(f);
                m_seen = '0;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] d, input logic [7:0] s, input int n);
        repeat (n) begin
            @(negedge clk);
            DIGS = d;
            SEGS = s;
            model_step(d, s);
        end
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] s3, input int hold);
        apply_stimulus(4'b0001, s0, hold);
        apply_stimulus(4'b0010, s1, hold);
        apply_stimulus(4'b0100, s2, hold);
        apply_stimulus(4'b1000, s3, hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        DIGS  = 4'b0000;
        SEGS  = 8'h00;
        repeat (3) @(negedge clk);
        check_output("reset_bcd", BCD, 16'h0000);
        check_output("reset_dot", DOT, 4'h0);
        check_output("reset_bi", BI, 1'b0);
        check_output("reset_valid", valid, 1'b0);
        check_output("reset_err", err, 4'h0);
        check_output("reset_stale", stale, 1'b0);
        reset   = 1'b1;
        m_run   = 0;
        m_seen  = '0;
        m_bcd   = '0;
        m_dot   = '0;
        m_err   = '0;
        m_blank = '0;
    endtask

    function automatic logic [7:0] rand_segs();
        int         pick;
        logic [7:0] s;
        pick = $urandom_range(0, 9);
        if (pick <= 5)      s = {1'($urandom_range(0, 1)), SEG_TABLE[$urandom_range(0, 9)]};
        else if (pick == 6) s = 8'h00;
        else if (pick == 7) s = 8'h80;
        else if (pick == 8) s = 8'($urandom_range(0, 255));
        else                s = 8'h01;
        return s;
    endfunction

    task automatic random_scan();
        int ord[4];
        int j;
        int t;
        for (int i = 0; i < 4; i++) ord[i] = i;
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 5) == 0)
                apply_stimulus(4'($urandom_range(0, 15)), rand_segs(), $urandom_range(3, 20));
            apply_stimulus(4'(1 << ord[k]), rand_segs(), $urandom_range(10, 24));
        end
    endtask

    // Monitor: pops an expected frame on every valid pulse, and between pulses
    // checks that the committed outputs hold their last values.
    initial begin
        frame_t      f;
        logic [15:0] h_bcd;
        logic [3:0]  h_dot;
        logic [3:0]  h_err;
        logic        h_bi;
        h_bcd = '0; h_dot = '0; h_err = '0; h_bi = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                h_bcd = '0; h_dot = '0; h_err = '0; h_bi = 1'b0;
            end else if (valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_valid", valid, 1'b0);
                end else begin
                    f = exp_q.pop_front();
                    check_output("frame_bcd", BCD, f.bcd);
                    check_output("frame_dot", DOT, f.dot);
                    check_output("frame_err", err, f.err);
                    check_output("frame_bi", BI, f.bi);
                    check_output("frame_cycle", cyc, f.due);
                    check_output("frame_stale", stale, 1'b0);
                    h_bcd = f.bcd; h_dot = f.dot; h_err = f.err; h_bi = f.bi;
                end
            end else begin
                check_output("hold", {BCD, DOT, err, BI}, {h_bcd, h_dot, h_err, h_bi});
                if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                    check_output("missing_valid", valid, 1'b1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();

        // Idle bus: watchdog fires exactly TIMEOUT clocks after reset release.
        repeat (TIMEOUT - 1) @(negedge clk);
        check_output("stale_before", stale, 1'b0);
        @(negedge clk);
        check_output("stale_at", stale, 1'b1);
        scan(8'h33, 8'h79, 8'h6D, 8'h30, 20);
        apply_stimulus(4'b0000, 8'h00, 4);
        check_output("stale_after", stale, 1'b0);

        // Digit 1 too short on the first pass, completed on the second.
        do_reset();
        apply_stimulus(4'b0001, 8'h33, 20);
        apply_stimulus(4'b0010, 8'h79, 10);
        apply_stimulus(4'b0100, 8'h6D, 20);
        apply_stimulus(4'b1000, 8'h30, 20);
        scan(8'h33, 8'h79, 8'h6D, 8'h30, 20);
        apply_stimulus(4'b0000, 8'h00, 4);

        // Dot on digit 2.
        do_reset();
        scan(8'h33, 8'h79, 8'hED, 8'h30, 20);
        apply_stimulus(4'b0000, 8'h00, 4);

        // Invalid pattern on digit 0, then a fully blank frame.
        do_reset();
        scan(8'h01, 8'h79, 8'h6D, 8'h30, 20);
        scan(8'h00, 8'h00, 8'h00, 8'h00, 20);
        apply_stimulus(4'b0000, 8'h00, 4);

        // Overlapping enables are ignored.
        do_reset();
        apply_stimulus(4'b0011, 8'h33, 40);
        scan(8'h7E, 8'h5B, 8'h5F, 8'h7B, STABLE);
        apply_stimulus(4'b0000, 8'h00, 4);

        // Reset after three digits: the remaining digit alone must not commit.
        do_reset();
        apply_stimulus(4'b0001, 8'h33, 20);
        apply_stimulus(4'b0010, 8'h79, 20);
        apply_stimulus(4'b0100, 8'h6D, 20);
        apply_stimulus(4'b0000, 8'h00, 2);
        do_reset();
        apply_stimulus(4'b1000, 8'h30, 20);
        apply_stimulus(4'b0000, 8'h00, 10);
        scan(8'h33, 8'h79, 8'h6D, 8'h30, 20);
        apply_stimulus(4'b0000, 8'h00, 4);

        // Randomized scans with junk interleaved.
        do_reset();
        repeat (40) random_scan();
        apply_stimulus(4'b0000, 8'h00, 10);

        check_output("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the four-digit multiplexed seven-segment driver.
- Samples the scanned DIGS/SEGS bus and reconstructs the 16-bit BCD value, the 4-bit DOT mask and the blank (BI) state.
- Used for loopback self-test and for monitoring a display bus.
- Flags invalid segment patterns and a stalled scan.

Parameters:
- STABLE_CNT, 16: consecutive clocks a {DIGS,SEGS} pair must stay unchanged before it is accepted (minimum 2).
- TIMEOUT, 200000: clocks without a completed frame before `stale` asserts.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- DIGS  input  4  digit enables; one-hot, bit n = digit n
- SEGS  input  8  [7]=dot, [6:0]=segments a..g (a = bit 6)
- BCD  output  16  reconstructed digits; digit n in BCD[4n+3:4n]
- DOT  output  4  reconstructed dot per digit
- BI  output  1  1 = last committed frame was fully blank
- valid  output  1  one-cycle pulse when a frame is committed
- err  output  4  per-digit invalid-pattern flag for the committed frame
- stale  output  1  no frame committed for TIMEOUT clocks

Behaviour:
- All state and outputs are cleared asynchronously while reset=0:
  - BCD=16'h0000, DOT=0, BI=0, valid=0, err=0, stale=0.
  - Seen mask = 0, stability counter = 0, timeout counter = 0.
- Input stage: {DIGS,SEGS} is registered once (s_reg). All logic operates on s_reg.
- Stability counter:
  - Resets to 0 whenever s_reg differs from its previous value; otherwise increments, saturating at STABLE_CNT.
  - Capture occurs on the single cycle the counter reaches STABLE_CNT-1.
  - At most one capture per stable period.
- Capture is performed only if DIGS in s_reg is one-hot. DIGS=0000 or multi-hot: no capture, no error.
- Segment decode, standard table, SEGS[6:0]:
  - 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9.
  - 00 = blank: nibble F, err bit 0.
  - Any other pattern: nibble F, err bit 1.
- Capture action:
  - Write the nibble, SEGS[7] and the err bit into the shadow slot for digit n.
  - Record "blank" when SEGS==8'h00; set seen[n].
  - Re-capturing a digit before the frame completes overwrites its slot. Arrival order is irrelevant.
- Commit, on the clock edge after the capture that makes seen==4'b1111:
  - Copy shadow to BCD/DOT/err.
  - BI=1 iff all four slots were blank (dots included).
  - valid=1 for exactly one cycle; seen cleared.
  - Capture-to-output latency is 1 clock; pin-to-output latency is STABLE_CNT+1 clocks after the last digit settles.
- A capture coinciding with a commit goes to the freshly cleared seen mask; it is not lost.
- Timeout:
  - The counter increments every clock, clears on commit, and saturates at TIMEOUT.
  - stale=1 while the counter equals TIMEOUT; it drops on the commit cycle.
- Outputs hold their values between commits.

Test Plan:
- STABLE_CNT=16. Scan DIGS 0001/0010/0100/1000 with SEGS 0x33/0x79/0x6D/0x30, 20 clocks each -> one valid pulse, BCD=16'h1234, DOT=0, err=0, BI=0.
- Same scan, but digit 1 held only 10 clocks on the first pass -> no valid until digit 1 is held ≥16 clocks on a later pass; then BCD=16'h1234.
- Digit 2 SEGS=0xED (dot + 2), others as above -> DOT=4'b0100, BCD=16'h1234.
- Digit 0 SEGS=0x01 -> BCD[3:0]=F, err=4'b0001, valid pulses. All four digits SEGS=0x00 -> BCD=16'hFFFF, BI=1, err=0.
- DIGS=4'b0011 held 40 clocks -> no capture, seen unchanged. With TIMEOUT=100 and no valid scan -> stale=1 at clock 100 after reset release; a subsequent complete scan clears stale on the commit cycle.
- Assert reset after three digits have been captured, then release and scan the remaining digit only -> no valid. A full four-digit scan is then required for a commit.
